// File: rtl/back_pressure_pkg.sv
// Shared types and constants for the back-pressure ready-pattern generator.
package back_pressure_pkg;

  localparam int unsigned BP_LFSR_W   = 16;
  localparam int unsigned BP_THRESH_W = 8;
  localparam int unsigned BP_MODE_W   = 2;

  localparam logic [BP_LFSR_W-1:0] BP_LFSR_MASK = 16'hB400;
  localparam logic [BP_LFSR_W-1:0] BP_RST_SEED  = 16'hACE1;

  typedef enum logic [BP_MODE_W-1:0] {
    BP_READY  = 2'd0,
    BP_NEVER  = 2'd1,
    BP_DUTY   = 2'd2,
    BP_RANDOM = 2'd3
  } bp_mode_e;

  typedef enum logic {
    BP_ON  = 1'b0,
    BP_OFF = 1'b1
  } bp_duty_state_e;

  // One Galois step: shift right, fold the mask in when a one falls out.
  function automatic logic [BP_LFSR_W-1:0] bp_lfsr_step(input logic [BP_LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ BP_LFSR_MASK) : (s >> 1);
  endfunction

  // The all-zero state would lock the LFSR, so it is never loaded.
  function automatic logic [BP_LFSR_W-1:0] bp_seed_fix(input logic [BP_LFSR_W-1:0] s);
    return (s == '0) ? BP_LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/bp_chan.sv
// One back-pressure channel: mode/config registers, DUTY FSM, LFSR, tready flop, counters.
// Stall counter is present only when BACK_PRESSURE_GEN_STATS_EN is defined.
module bp_chan
  import back_pressure_pkg::*;
#(
  parameter int unsigned CH    = 0,
  parameter int unsigned CW    = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   cfg_load,
  input  logic [BP_MODE_W-1:0]   cfg_mode,
  input  logic [CW-1:0]          cfg_on_len,
  input  logic [CW-1:0]          cfg_off_len,
  input  logic [BP_THRESH_W-1:0] cfg_thresh,
  input  logic [BP_LFSR_W-1:0]   cfg_seed,
  input  logic                   tvalid,
  output logic                   tready,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam logic [BP_LFSR_W-1:0] CH_SALT = BP_LFSR_W'(CH);

  bp_mode_e              r_mode,    w_mode_nxt;
  logic [CW-1:0]         r_on_len,  w_on_len_nxt;
  logic [CW-1:0]         r_off_len, w_off_len_nxt;
  logic [BP_THRESH_W-1:0] r_thresh, w_thresh_nxt;
  bp_duty_state_e        r_state,   w_state_nxt;
  logic [CW-1:0]         r_cnt,     w_cnt_nxt;
  logic [BP_LFSR_W-1:0]  r_lfsr,    w_lfsr_nxt;
  logic                  r_tready,  w_tready_nxt;
  logic [CNT_W-1:0]      r_beat,    w_beat_nxt;

  // ON phase lasts max(len,1) cycles; the counter holds remaining cycles minus one.
  function automatic logic [CW-1:0] on_reload(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - CW'(1);
  endfunction

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_mode    <= BP_READY;
      r_on_len  <= CW'(1);
      r_off_len <= CW'(1);
      r_thresh  <= '0;
      r_state   <= BP_ON;
      r_cnt     <= '0;
      r_lfsr    <= BP_RST_SEED ^ CH_SALT;
      r_tready  <= 1'b0;
      r_beat    <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_on_len  <= w_on_len_nxt;
      r_off_len <= w_off_len_nxt;
      r_thresh  <= w_thresh_nxt;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_tready  <= w_tready_nxt;
      r_beat    <= w_beat_nxt;
    end
  end

  // tready is always derived from the next mode state, so it tracks the registered LFSR/phase.
  always_comb begin
    w_mode_nxt    = r_mode;
    w_on_len_nxt  = r_on_len;
    w_off_len_nxt = r_off_len;
    w_thresh_nxt  = r_thresh;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lfsr_nxt    = bp_lfsr_step(r_lfsr);
    w_tready_nxt  = 1'b0;
    w_beat_nxt    = r_beat + CNT_W'(tvalid & r_tready);

    if (cfg_load) begin
      w_mode_nxt    = bp_mode_e'(cfg_mode);
      w_on_len_nxt  = cfg_on_len;
      w_off_len_nxt = cfg_off_len;
      w_thresh_nxt  = cfg_thresh;
      w_state_nxt   = BP_ON;
      w_cnt_nxt     = on_reload(cfg_on_len);
      w_lfsr_nxt    = bp_seed_fix(cfg_seed ^ CH_SALT);
      w_beat_nxt    = '0;
    end else if (r_mode == BP_DUTY) begin
      unique case (r_state)
        BP_ON: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else if (r_off_len == '0) begin
            w_cnt_nxt = on_reload(r_on_len);
          end else begin
            w_state_nxt = BP_OFF;
            w_cnt_nxt   = r_off_len - CW'(1);
          end
        end
        BP_OFF: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_state_nxt = BP_ON;
            w_cnt_nxt   = on_reload(r_on_len);
          end
        end
      endcase
    end

    unique case (w_mode_nxt)
      BP_READY:  w_tready_nxt = 1'b1;
      BP_NEVER:  w_tready_nxt = 1'b0;
      BP_DUTY:   w_tready_nxt = (w_state_nxt == BP_ON);
      BP_RANDOM: w_tready_nxt = (w_lfsr_nxt[BP_THRESH_W-1:0] < w_thresh_nxt);
    endcase
  end

  assign tready   = r_tready;
  assign beat_cnt = r_beat;

`ifdef BACK_PRESSURE_GEN_STATS_EN
  logic [CNT_W-1:0] r_stall, w_stall_nxt;

  // Saturating count of cycles where the producer waited on us.
  always_comb begin
    w_stall_nxt = r_stall;
    if (cfg_load) begin
      w_stall_nxt = '0;
    end else if (tvalid && !r_tready && (r_stall != '1)) begin
      w_stall_nxt = r_stall + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_stall <= '0;
    end else begin
      r_stall <= w_stall_nxt;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: rtl/back_pressure_gen.sv
// Per-channel programmable tready pattern generator with accepted-beat counters.
// Define BACK_PRESSURE_GEN_STATS_EN to build the saturating stall counters.
module back_pressure_gen
  import back_pressure_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic                         cfg_load,
  input  logic [BP_MODE_W*NCH-1:0]     cfg_mode,
  input  logic [CW*NCH-1:0]            cfg_on_len,
  input  logic [CW*NCH-1:0]            cfg_off_len,
  input  logic [BP_THRESH_W*NCH-1:0]   cfg_thresh,
  input  logic [BP_LFSR_W-1:0]         cfg_seed,
  input  logic [NCH-1:0]               tvalid,
  output logic [NCH-1:0]               tready,
  output logic [CNT_W*NCH-1:0]         beat_cnt,
  output logic [CNT_W*NCH-1:0]         stall_cnt
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    bp_chan #(
      .CH    (i),
      .CW    (CW),
      .CNT_W (CNT_W)
    ) u_chan (
      .aclk        (aclk),
      .arst        (arst),
      .cfg_load    (cfg_load),
      .cfg_mode    (cfg_mode[BP_MODE_W*i +: BP_MODE_W]),
      .cfg_on_len  (cfg_on_len[CW*i +: CW]),
      .cfg_off_len (cfg_off_len[CW*i +: CW]),
      .cfg_thresh  (cfg_thresh[BP_THRESH_W*i +: BP_THRESH_W]),
      .cfg_seed    (cfg_seed),
      .tvalid      (tvalid[i]),
      .tready      (tready[i]),
      .beat_cnt    (beat_cnt[CNT_W*i +: CNT_W]),
      .stall_cnt   (stall_cnt[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_back_pressure_gen.sv
// Scoreboard bench for back_pressure_gen: directed stimulus queues expectations, a monitor checks them.
module tb_back_pressure_gen;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned CNT_W = 32;

`ifdef BACK_PRESSURE_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 aclk = 1'b0;
  logic                 arst;
  logic                 cfg_load;
  logic [2*NCH-1:0]     cfg_mode;
  logic [CW*NCH-1:0]    cfg_on_len;
  logic [CW*NCH-1:0]    cfg_off_len;
  logic [8*NCH-1:0]     cfg_thresh;
  logic [15:0]          cfg_seed;
  logic [NCH-1:0]       tvalid;
  logic [NCH-1:0]       tready;
  logic [CNT_W*NCH-1:0] beat_cnt;
  logic [CNT_W*NCH-1:0] stall_cnt;

  back_pressure_gen #(.NCH(NCH), .CW(CW), .CNT_W(CNT_W)) dut (
    .aclk        (aclk),
    .arst        (arst),
    .cfg_load    (cfg_load),
    .cfg_mode    (cfg_mode),
    .cfg_on_len  (cfg_on_len),
    .cfg_off_len (cfg_off_len),
    .cfg_thresh  (cfg_thresh),
    .cfg_seed    (cfg_seed),
    .tvalid      (tvalid),
    .tready      (tready),
    .beat_cnt    (beat_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // sel: 0 tready vector, 1 tready bit, 2 beat_cnt, 3 stall_cnt, 4 ch2 ready-ratio window
  typedef struct {
    int          cyc;
    int          sel;
    int          ch;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ones2    = 0;
  exp_t        m_e;
  logic [31:0] m_act;
  bit          m_ok;

  always @(negedge aclk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d never evaluated (now %0d)", m_e.name, m_e.cyc, cyc);
      end else begin
        case (m_e.sel)
          0:       m_act = 32'(tready);
          1:       m_act = 32'(tready[m_e.ch]);
          2:       m_act = beat_cnt[m_e.ch*CNT_W +: CNT_W];
          3:       m_act = stall_cnt[m_e.ch*CNT_W +: CNT_W];
          default: m_act = 32'(ones2);
        endcase
        if (m_e.sel == 4) begin
          m_ok = (ones2 >= 1925) && (ones2 <= 2171);
        end else begin
          m_ok = (m_act === m_e.exp);
        end
        if (m_e.sel == 1 && m_e.ch == 2) ones2 += int'(m_act);
        if (!m_ok) begin
          n_fail++;
          if (m_e.sel == 4)
            $display("FAIL %s @cyc %0d: ready count %0d of 4096, required 1925..2171", m_e.name, cyc, ones2);
          else
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", m_e.name, cyc, m_act, m_e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input int ch, input logic [31:0] v, input string nm);
    exp_t t;
    t.cyc = cyc; t.sel = sel; t.ch = ch; t.exp = v; t.name = nm;
    q.push_back(t);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_load();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic set_ch(input int ch, input logic [1:0] md, input logic [7:0] on,
                        input logic [7:0] off, input logic [7:0] th);
    cfg_mode[2*ch +: 2]    = md;
    cfg_on_len[8*ch +: 8]  = on;
    cfg_off_len[8*ch +: 8] = off;
    cfg_thresh[8*ch +: 8]  = th;
  endtask

  logic [15:0] m;

  initial begin
    arst = 1'b1; cfg_load = 1'b0; tvalid = '0; cfg_seed = 16'h1234;
    for (int c = 0; c < NCH; c++) set_ch(c, 2'd0, 8'd1, 8'd1, 8'd0);
    repeat (3) tick();

    // Reset state, then always-ready after release
    expect_val(0, 0, 32'h0, "rst_tready");
    expect_val(2, 0, 32'd0, "rst_beat0");
    expect_val(3, 0, 32'd0, "rst_stall0");
    arst = 1'b0;
    tick();
    expect_val(0, 0, 32'hF, "post_rst_tready");
    tvalid = 4'hF;
    repeat (10) tick();
    for (int c = 0; c < NCH; c++) expect_val(2, c, 32'd10, "ready_beats");
    tvalid = '0;
    tick();

    // ch0 DUTY on=3 off=2
    set_ch(0, 2'd2, 8'd3, 8'd2, 8'd0);
    do_load();
    tvalid = 4'b0001;
    for (int j = 0; j < 20; j++) begin
      expect_val(1, 0, ((j % 5) < 3) ? 32'd1 : 32'd0, "duty_tready0");
      tick();
    end
    expect_val(2, 0, 32'd12, "duty_beat0");
    expect_val(3, 0, STATS ? 32'd8 : 32'd0, "duty_stall0");
    tvalid = '0;

    // ch1 NEVER
    set_ch(1, 2'd1, 8'd1, 8'd1, 8'd0);
    do_load();
    tvalid = 4'b0010;
    for (int j = 0; j < 8; j++) begin
      expect_val(1, 1, 32'd0, "never_tready1");
      tick();
    end
    expect_val(2, 1, 32'd0, "never_beat1");
    expect_val(3, 1, STATS ? 32'd8 : 32'd0, "never_stall1");
    tvalid = '0;

    // ch2 RANDOM thresh=128 seed 0x1234, bit-exact against reference LFSR
    set_ch(2, 2'd3, 8'd1, 8'd1, 8'd128);
    do_load();
    m = 16'h1234 ^ 16'd2;
    for (int j = 0; j < 4096; j++) begin
      expect_val(1, 2, (m[7:0] < 8'd128) ? 32'd1 : 32'd0, "rand_tready2");
      m = ref_step(m);
      tick();
    end
    expect_val(4, 2, 32'd1, "rand_ratio2");

    // ch3 RANDOM thresh=0 then thresh=255
    set_ch(3, 2'd3, 8'd1, 8'd1, 8'd0);
    do_load();
    for (int j = 0; j < 16; j++) begin
      expect_val(1, 3, 32'd0, "rand_th0_tready3");
      tick();
    end
    set_ch(3, 2'd3, 8'd1, 8'd1, 8'd255);
    do_load();
    m = 16'h1234 ^ 16'd3;
    for (int j = 0; j < 2048; j++) begin
      expect_val(1, 3, (m[7:0] != 8'hFF) ? 32'd1 : 32'd0, "rand_th255_tready3");
      m = ref_step(m);
      tick();
    end

    // Beat coinciding with cfg_load is dropped
    for (int c = 0; c < NCH; c++) set_ch(c, 2'd0, 8'd1, 8'd1, 8'd0);
    do_load();
    expect_val(0, 0, 32'hF, "load_ready_tready");
    tvalid = 4'hF;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    expect_val(2, 0, 32'd0, "load_beat_dropped0");
    expect_val(2, 3, 32'd0, "load_beat_dropped3");
    tick();
    expect_val(2, 0, 32'd1, "post_load_beat0");
    tvalid = '0;

    // Mid-DUTY-OFF reset colliding with a load
    set_ch(0, 2'd2, 8'd3, 8'd2, 8'd0);
    do_load();
    tvalid = 4'hF;
    repeat (3) tick();
    expect_val(1, 0, 32'd0, "pre_rst_off_phase");
    expect_val(2, 0, 32'd3, "pre_rst_beat0");
    arst = 1'b1;
    cfg_load = 1'b1;
    set_ch(0, 2'd1, 8'd1, 8'd1, 8'd0);
    tick();
    arst = 1'b0;
    cfg_load = 1'b0;
    expect_val(0, 0, 32'h0, "midrst_tready");
    for (int c = 0; c < NCH; c++) expect_val(2, c, 32'd0, "midrst_beat");
    expect_val(3, 0, 32'd0, "midrst_stall0");
    tick();
    expect_val(0, 0, 32'hF, "midrst_release_tready");
    expect_val(2, 0, 32'd0, "midrst_release_beat0");
    expect_val(3, 0, STATS ? 32'd1 : 32'd0, "midrst_release_stall0");
    tick();
    expect_val(2, 0, 32'd1, "midrst_beat0");
    expect_val(2, 2, 32'd1, "midrst_beat2");
    tvalid = '0;

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
